// File: rtl/seg7_pkg.sv
// Shared 7-segment constants: the encoder and the scan capture both use
// these so encode and decode can never drift apart.
package seg7_pkg;

  // Segment order {a,b,c,d,e,f,g}, bit 6 = a, active-high.
  localparam logic [6:0] SEG_PAT_0     = 7'b1111110;
  localparam logic [6:0] SEG_PAT_1     = 7'b0110000;
  localparam logic [6:0] SEG_PAT_2     = 7'b1101101;
  localparam logic [6:0] SEG_PAT_3     = 7'b1111001;
  localparam logic [6:0] SEG_PAT_4     = 7'b0110011;
  localparam logic [6:0] SEG_PAT_5     = 7'b1011011;
  localparam logic [6:0] SEG_PAT_6     = 7'b1011111;
  localparam logic [6:0] SEG_PAT_7     = 7'b1110000;
  localparam logic [6:0] SEG_PAT_8     = 7'b1111111;
  localparam logic [6:0] SEG_PAT_9     = 7'b1111011;
  localparam logic [6:0] SEG_PAT_BLANK = 7'b0000000;

  // Out-of-range BCD codes that flag a blank or undecodable digit.
  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_ERR   = 4'hE;

  typedef enum logic {
    HUNT = 1'b0,  // waiting for a digit dwell to settle
    HOLD = 1'b1   // dwell captured, waiting for it to end
  } cap_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to BCD decode, inverse of the encode table.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_pat,
  output logic [3:0] o_bcd,
  output logic       o_err,
  output logic       o_blank
);

  // Legal digits map to 0-9; the flags fall out of the two reserved codes.
  always_comb begin
    o_bcd = BCD_ERR;
    case (i_pat)
      SEG_PAT_0:     o_bcd = 4'd0;
      SEG_PAT_1:     o_bcd = 4'd1;
      SEG_PAT_2:     o_bcd = 4'd2;
      SEG_PAT_3:     o_bcd = 4'd3;
      SEG_PAT_4:     o_bcd = 4'd4;
      SEG_PAT_5:     o_bcd = 4'd5;
      SEG_PAT_6:     o_bcd = 4'd6;
      SEG_PAT_7:     o_bcd = 4'd7;
      SEG_PAT_8:     o_bcd = 4'd8;
      SEG_PAT_9:     o_bcd = 4'd9;
      SEG_PAT_BLANK: o_bcd = BCD_BLANK;
      default:       o_bcd = BCD_ERR;
    endcase
    o_err   = (o_bcd == BCD_ERR);
    o_blank = (o_bcd == BCD_BLANK);
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Samples a multiplexed 7-segment bus, captures each digit once per stable
// dwell, and emits one decoded frame per full scan on a valid/ready port.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow,
  input  logic                    clr_ovf
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [6:0]                  r_seg_m, r_seg_q;
  logic [NUM_DIGITS-1:0]       r_den_m, r_den_q;
  logic [6:0]                  w_seg_s;
  logic [NUM_DIGITS-1:0]       w_den_s;
  logic [NUM_DIGITS+6:0]       r_prev;
  logic                        w_match, w_onehot, w_stable, w_capture;
  logic [CW-1:0]               r_cnt, w_cnt_nxt;
  cap_state_e                  r_state;
  logic [3:0]                  w_dec_bcd;
  logic                        w_dec_err, w_dec_blank;
  logic [NUM_DIGITS-1:0][3:0]  r_slot_bcd;
  logic [NUM_DIGITS-1:0]       r_slot_err, r_slot_blank, r_mask;
  logic                        w_complete, w_load, w_drop;
  logic [4*NUM_DIGITS-1:0]     r_bcd;
  logic [NUM_DIGITS-1:0]       r_err, r_blank;
  logic                        r_valid, r_ovf;

  // Two-flop synchronizers for the asynchronous panel lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_m <= '0;
      r_seg_q <= '0;
      r_den_m <= '0;
      r_den_q <= '0;
    end else begin
      r_seg_m <= seg_in;
      r_seg_q <= r_seg_m;
      r_den_m <= dig_en;
      r_den_q <= r_den_m;
    end
  end

  assign w_seg_s  = SEG_ACTIVE_LOW ? ~r_seg_q : r_seg_q;
  assign w_den_s  = DIG_ACTIVE_LOW ? ~r_den_q : r_den_q;
  assign w_onehot = $onehot(w_den_s);
  assign w_match  = ({w_seg_s, w_den_s} == r_prev);

  // Run length of unchanged one-hot samples, saturating. STABLE_CYCLES
  // identical samples means STABLE_CYCLES-1 matches against the previous one,
  // so capture lands STABLE_CYCLES-1 cycles after the first sample.
  always_comb begin
    w_cnt_nxt = '0;
    if (w_match && w_onehot)
      w_cnt_nxt = (r_cnt == CW'(STABLE_CYCLES)) ? r_cnt : r_cnt + 1'b1;
  end

  assign w_stable  = (w_cnt_nxt >= CW'(STABLE_CYCLES - 1));
  assign w_capture = (r_state == HUNT) && w_stable;

  seg7_pattern_decode u_dec (
    .i_pat   (w_seg_s),
    .o_bcd   (w_dec_bcd),
    .o_err   (w_dec_err),
    .o_blank (w_dec_blank)
  );

  // Dwell tracker: one capture per dwell, re-armed when the bus changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev  <= '0;
      r_cnt   <= '0;
      r_state <= HUNT;
    end else begin
      r_prev <= {w_seg_s, w_den_s};
      r_cnt  <= w_cnt_nxt;
      case (r_state)
        HUNT:    if (w_capture) r_state <= HOLD;
        HOLD:    if (!(w_match && w_onehot)) r_state <= HUNT;
        default: r_state <= HUNT;
      endcase
    end
  end

  assign w_complete = &r_mask;
  assign w_load     = w_complete && (!r_valid || out_ready);
  assign w_drop     = w_complete && r_valid && !out_ready;

  // Working slots; den_s is one-hot on capture so it doubles as the mask bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_bcd   <= '0;
      r_slot_err   <= '0;
      r_slot_blank <= '0;
      r_mask       <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_capture && w_den_s[i]) begin
          r_slot_bcd[i]   <= w_dec_bcd;
          r_slot_err[i]   <= w_dec_err;
          r_slot_blank[i] <= w_dec_blank;
        end
      end
      r_mask <= (w_complete ? '0 : r_mask) | (w_capture ? w_den_s : '0);
    end
  end

  // Output frame register and handshake; a pending frame is never disturbed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd   <= '0;
      r_err   <= '0;
      r_blank <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_load) begin
        r_bcd   <= r_slot_bcd;
        r_err   <= r_slot_err;
        r_blank <= r_slot_blank;
        r_valid <= 1'b1;
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  assign bcd_out     = r_bcd;
  assign digit_err   = r_err;
  assign digit_blank = r_blank;
  assign out_valid   = r_valid;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture: directed scans plus a random dwell stream,
// checked against a dwell-level model. A second instance sees the same panel
// through inverted segment and digit lines.
module tb_seg7_scan_capture;

  localparam int S = 4;
  localparam logic [6:0] ENC [0:9] = '{7'b1111110, 7'b0110000, 7'b1101101,
    7'b1111001, 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111,
    7'b1111011};

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  err;
    logic [3:0]  blank;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n, ready, clr;
  logic [6:0] seg;
  logic [3:0] den;
  logic [6:0] seg_n;
  logic [3:0] den_n;
  logic [15:0] bcd_a, bcd_b;
  logic [3:0] err_a, err_b, blank_a, blank_b;
  logic valid_a, valid_b, ovf_a, ovf_b;

  assign seg_n = ~seg;
  assign den_n = ~den;

  seg7_scan_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(S), .SEG_ACTIVE_LOW(1'b0),
    .DIG_ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .seg_in(seg), .dig_en(den), .bcd_out(bcd_a),
    .digit_err(err_a), .digit_blank(blank_a), .out_valid(valid_a),
    .out_ready(ready), .overflow(ovf_a), .clr_ovf(clr));

  seg7_scan_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(S), .SEG_ACTIVE_LOW(1'b1),
    .DIG_ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_n), .dig_en(den_n), .bcd_out(bcd_b),
    .digit_err(err_b), .digit_blank(blank_b), .out_valid(valid_b),
    .out_ready(ready), .overflow(ovf_b), .clr_ovf(clr));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int vcyc_a = 0;
  frame_t got_a[$], got_b[$], exp_q[$];
  logic [3:0] m_bcd [0:3];
  logic [3:0] m_err, m_blank, m_mask;

  // Record every accepted frame of both instances.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_a && ready) got_a.push_back({bcd_a, err_a, blank_a});
      if (valid_b && ready) got_b.push_back({bcd_b, err_b, blank_b});
      if (valid_a) vcyc_a++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode: table lookup over the legal digits.
  function automatic logic [5:0] dec_model(input logic [6:0] p);
    for (int k = 0; k < 10; k++)
      if (p == ENC[k]) return {4'(k), 2'b00};
    if (p == 7'b0) return {4'hF, 2'b01};
    return {4'hE, 2'b10};
  endfunction

  // A dwell of at least S cycles yields one capture; a full set emits a frame.
  task automatic model_cap(input int d, input logic [6:0] p);
    logic [5:0] r;
    r = dec_model(p);
    m_bcd[d] = r[5:2];
    m_err[d] = r[1];
    m_blank[d] = r[0];
    m_mask[d] = 1'b1;
    if (m_mask == 4'hF) begin
      exp_q.push_back({m_bcd[3], m_bcd[2], m_bcd[1], m_bcd[0], m_err, m_blank});
      m_mask = 4'h0;
    end
  endtask

  task automatic dwell(input int d, input logic [6:0] p, input int len);
    seg = p;
    den = 4'(1 << d);
    repeat (len) @(posedge clk);
    #1;
    if (len >= S) model_cap(d, p);
  endtask

  task automatic idle(input int n);
    seg = 7'b0;
    den = 4'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_frames(input string tag);
    chk({tag, "_cnt_a"}, 32'(got_a.size()), 32'(exp_q.size()));
    chk({tag, "_cnt_b"}, 32'(got_b.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_a.size()) chk({tag, "_frm_a"}, 32'(got_a[i]), 32'(exp_q[i]));
      if (i < got_b.size()) chk({tag, "_frm_b"}, 32'(got_b[i]), 32'(exp_q[i]));
    end
    got_a.delete();
    got_b.delete();
    exp_q.delete();
  endtask

  task automatic scan4(input int v0, input int v1, input int v2, input int v3);
    dwell(0, ENC[v0], 10);
    dwell(1, ENC[v1], 10);
    dwell(2, ENC[v2], 10);
    dwell(3, ENC[v3], 10);
  endtask

  initial begin
    int prev_d, d, r, len;
    logic [6:0] p;
    seg = 7'b0; den = 4'b0; ready = 1'b1; clr = 1'b0; rst_n = 1'b0;
    m_mask = 4'h0; m_err = 4'h0; m_blank = 4'h0;
    for (int i = 0; i < 4; i++) m_bcd[i] = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bcd", 32'(bcd_a), 32'h0);
    chk("rst_flags", 32'({err_a, blank_a}), 32'h0);
    chk("rst_valid", 32'(valid_a), 32'h0);
    chk("rst_ovf", 32'(ovf_a), 32'h0);
    chk("rst_b", 32'({bcd_b, err_b, blank_b, valid_b, ovf_b}), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Basic scan 1,2,3,4 with the consumer always ready.
    vcyc_a = 0;
    scan4(1, 2, 3, 4);
    idle(6);
    chk("s1_bcd", 32'(bcd_a), 32'h4321);
    chk("s1_flags", 32'({err_a, blank_a}), 32'h0);
    chk("s1_vpulse", 32'(vcyc_a), 32'd1);
    check_frames("s1");

    // Short dwell on digit 2 is ignored until a proper dwell follows.
    dwell(0, ENC[1], 10);
    dwell(1, ENC[2], 10);
    dwell(2, ENC[3], 3);
    dwell(3, ENC[4], 10);
    idle(6);
    chk("s2_nofrm", 32'(got_a.size()), 32'd0);
    chk("s2_novalid", 32'(valid_a), 32'd0);
    dwell(2, ENC[3], 10);
    idle(6);
    chk("s2_bcd", 32'(bcd_a), 32'h4321);
    check_frames("s2");

    // Error and blank patterns.
    dwell(0, ENC[5], 10);
    dwell(1, 7'b0000001, 10);
    dwell(2, ENC[8], 10);
    dwell(3, 7'b0000000, 10);
    idle(6);
    chk("s3_bcd", 32'(bcd_a), 32'hF8E5);
    chk("s3_err", 32'(err_a), 32'b0010);
    chk("s3_blank", 32'(blank_a), 32'b1000);
    check_frames("s3");

    // Back-pressure: second frame dropped, first held, overflow sticky.
    ready = 1'b0;
    scan4(8, 7, 6, 5);
    idle(6);
    chk("s4_valid1", 32'(valid_a), 32'd1);
    chk("s4_ovf0", 32'(ovf_a), 32'd0);
    scan4(9, 0, 1, 2);
    idle(6);
    chk("s4_hold", 32'(bcd_a), 32'h5678);
    chk("s4_ovf1", 32'({ovf_a, ovf_b}), 32'b11);
    exp_q.delete(1);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("s4_clr", 32'({ovf_a, ovf_b}), 32'b00);
    chk("s4_still", 32'(valid_a), 32'd1);
    ready = 1'b1;
    @(posedge clk); #1;
    chk("s4_fall", 32'({valid_a, valid_b}), 32'b00);
    idle(2);
    check_frames("s4");

    // Two-hot and all-off enables never capture nor disturb the mask.
    dwell(0, ENC[1], 10);
    dwell(1, ENC[2], 10);
    seg = ENC[8]; den = 4'b0011;
    repeat (20) @(posedge clk);
    #1;
    idle(20);
    chk("s5_nofrm", 32'(got_a.size()), 32'd0);
    dwell(2, ENC[3], 10);
    dwell(3, ENC[4], 10);
    idle(6);
    chk("s5_bcd", 32'(bcd_a), 32'h4321);
    check_frames("s5");

    // Asynchronous reset mid-frame with a held frame and overflow pending.
    ready = 1'b0;
    dwell(0, ENC[9], 10);
    dwell(1, 7'b0000001, 10);
    dwell(2, ENC[9], 10);
    dwell(3, 7'b0000000, 10);
    scan4(1, 1, 1, 1);
    idle(6);
    chk("s6_pre", 32'({bcd_a, err_a, blank_a, valid_a, ovf_a}),
        32'({16'hF9E9, 4'b0010, 4'b1000, 1'b1, 1'b1}));
    dwell(0, ENC[1], 10);
    dwell(1, ENC[2], 10);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_rst_a", 32'({bcd_a, err_a, blank_a, valid_a, ovf_a}), 32'h0);
    chk("s6_rst_b", 32'({bcd_b, err_b, blank_b, valid_b, ovf_b}), 32'h0);
    @(posedge clk); #1;
    got_a.delete(); got_b.delete(); exp_q.delete();
    m_mask = 4'h0;
    rst_n = 1'b1;
    ready = 1'b1;
    idle(2);
    dwell(2, ENC[3], 10);
    dwell(3, ENC[4], 10);
    idle(6);
    chk("s6_partial", 32'(got_a.size()), 32'd0);
    scan4(1, 2, 3, 4);
    idle(6);
    check_frames("s6");

    // Random dwell stream: mixed digits, patterns and lengths around S.
    prev_d = -1;
    for (int n = 0; n < 60; n++) begin
      do d = int'($urandom_range(0, 3)); while (d == prev_d);
      prev_d = d;
      r = int'($urandom_range(0, 9));
      if (r < 7)       p = ENC[$urandom_range(0, 9)];
      else if (r == 7) p = 7'b0;
      else             p = 7'($urandom);
      if ($urandom_range(0, 3) == 0) len = int'($urandom_range(1, S - 1));
      else                           len = int'($urandom_range(S, 12));
      dwell(d, p, len);
    end
    idle(6);
    check_frames("rnd");
    chk("rnd_ovf", 32'({ovf_a, ovf_b}), 32'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
